// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the memory (slave).
// The request fields are held stable from the first req cycle until ack.
interface mem_stage_if;
  logic        proc2mem_req;
  logic        proc2mem_we;
  logic [31:0] proc2mem_addr;
  logic [31:0] proc2mem_data;
  logic [3:0]  proc2mem_be;
  logic        mem2proc_ack;
  logic [31:0] mem2proc_data;

  modport master (
    output proc2mem_req, proc2mem_we, proc2mem_addr, proc2mem_data, proc2mem_be,
    input  mem2proc_ack, mem2proc_data
  );

  modport slave (
    input  proc2mem_req, proc2mem_we, proc2mem_addr, proc2mem_data, proc2mem_be,
    output mem2proc_ack, mem2proc_data
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack bus,
// stalls upstream while an access is in flight, aligns and extends load data.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid_inst,
  input  logic        ex_mem_rd_mem,
  input  logic        ex_mem_wr_mem,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_regb,
  input  logic [2:0]  ex_mem_funct3,
  mem_stage_if.master bus,
  output logic        mem_stall,
  output logic        mem_valid_out,
  output logic [31:0] mem_result_out,
  output logic        mem_err_out,
  output logic [1:0]  mem_state_dbg
);

  localparam int          CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [31:0] BAD_VAL = 32'hbaadbeef;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic        r_req, r_we;
  logic [31:0] r_addr, r_data, r_result;
  logic [3:0]  r_be;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [CW-1:0] r_cnt;
  logic        r_err;

  logic        w_legal, w_aligned, w_start, w_timeout;
  logic [31:0] w_st_data, w_load;
  logic [3:0]  w_st_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Decode of the incoming instruction; only the low two funct3 bits carry size.
  always_comb begin
    w_legal   = ex_mem_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    w_aligned = 1'b1;
    w_st_data = ex_mem_regb;
    w_st_be   = 4'b1111;
    case (ex_mem_funct3[1:0])
      2'b00: begin
        w_st_data = {4{ex_mem_regb[7:0]}};
        w_st_be   = 4'b0001 << ex_mem_alu_result[1:0];
      end
      2'b01: begin
        w_aligned = ~ex_mem_alu_result[0];
        w_st_data = {2{ex_mem_regb[15:0]}};
        w_st_be   = ex_mem_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   w_aligned = (ex_mem_alu_result[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
    w_start   = ex_mem_valid_inst & (ex_mem_rd_mem ^ ex_mem_wr_mem) & w_legal & w_aligned;
    w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    w_byte = bus.mem2proc_data[7:0];
    case (r_lane)
      2'd1:    w_byte = bus.mem2proc_data[15:8];
      2'd2:    w_byte = bus.mem2proc_data[23:16];
      2'd3:    w_byte = bus.mem2proc_data[31:24];
      default: w_byte = bus.mem2proc_data[7:0];
    endcase
    w_half = r_lane[1] ? bus.mem2proc_data[31:16] : bus.mem2proc_data[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'b0, w_byte};
      3'b101:  w_load = {16'b0, w_half};
      default: w_load = bus.mem2proc_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    mem_stall      = 1'b0;
    mem_valid_out  = 1'b0;
    mem_result_out = 32'b0;
    mem_err_out    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          mem_stall = 1'b1;
          w_next    = S_BUSY;
        end else if (ex_mem_valid_inst) begin
          mem_valid_out = 1'b1;
          // Any memory op that failed the start test is malformed.
          if (ex_mem_rd_mem | ex_mem_wr_mem) begin
            mem_result_out = BAD_VAL;
            mem_err_out    = 1'b1;
          end else begin
            mem_result_out = ex_mem_alu_result;
          end
        end
      end
      S_BUSY: begin
        mem_stall = 1'b1;
        if (bus.mem2proc_ack | w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        mem_valid_out  = 1'b1;
        mem_result_out = r_result;
        mem_err_out    = r_err;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'b0;
      r_data   <= 32'b0;
      r_be     <= 4'b0;
      r_funct3 <= 3'b0;
      r_lane   <= 2'b0;
      r_cnt    <= '0;
      r_result <= 32'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_req    <= 1'b1;
          r_we     <= ex_mem_wr_mem;
          r_addr   <= {ex_mem_alu_result[31:2], 2'b00};
          r_data   <= ex_mem_wr_mem ? w_st_data : 32'b0;
          r_be     <= ex_mem_wr_mem ? w_st_be : 4'b1111;
          r_funct3 <= ex_mem_funct3;
          r_lane   <= ex_mem_alu_result[1:0];
          r_cnt    <= '0;
          r_result <= 32'b0;
          r_err    <= 1'b0;
        end
        S_BUSY: begin
          if (bus.mem2proc_ack) begin
            r_req    <= 1'b0;
            r_result <= r_we ? 32'b0 : w_load;
            r_err    <= 1'b0;
          end else if (w_timeout) begin
            r_req    <= 1'b0;
            r_result <= BAD_VAL;
            r_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.proc2mem_req  = r_req;
  assign bus.proc2mem_we   = r_we;
  assign bus.proc2mem_addr = r_addr;
  assign bus.proc2mem_data = r_data;
  assign bus.proc2mem_be   = r_be;
  assign mem_state_dbg     = r_state;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed loads, stores, error cases,
// timeout and reset-during-access against a short timeout.
module tb_mem_stage;
  localparam int T = 8;

  logic        clk, rst;
  logic        valid, rd, wr;
  logic [31:0] alu, regb;
  logic [2:0]  f3;
  logic        stall, vout, err;
  logic [31:0] result;
  logic [1:0]  st;
  int          n_pass, n_fail, n_total;

  mem_stage_if bus_if ();

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid_inst(valid), .ex_mem_rd_mem(rd), .ex_mem_wr_mem(wr),
    .ex_mem_alu_result(alu), .ex_mem_regb(regb), .ex_mem_funct3(f3),
    .bus(bus_if.master),
    .mem_stall(stall), .mem_valid_out(vout), .mem_result_out(result),
    .mem_err_out(err), .mem_state_dbg(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a memory instruction in IDLE; returns in the first BUSY cycle.
  task automatic issue(input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    valid = 1'b1; rd = r; wr = w; f3 = f; alu = a; regb = b;
    #1;
    chk("accept_stall", stall, 1);
    chk("accept_noreq", bus_if.proc2mem_req, 0);
    chk("accept_novalid", vout, 0);
    tick();
    chk("busy_req", bus_if.proc2mem_req, 1);
    chk("busy_stall", stall, 1);
  endtask

  // Ack in the current BUSY cycle; returns in the DONE cycle.
  task automatic ack_with(input logic [31:0] d);
    bus_if.mem2proc_ack = 1'b1; bus_if.mem2proc_data = d;
    tick();
    bus_if.mem2proc_ack = 1'b0; valid = 1'b0; rd = 1'b0; wr = 1'b0;
    #1;
    chk("done_stall", stall, 0);
    chk("done_valid", vout, 1);
    chk("done_req", bus_if.proc2mem_req, 0);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst = 1'b1; valid = 1'b0; rd = 1'b0; wr = 1'b0;
    alu = 32'b0; regb = 32'b0; f3 = 3'b0;
    bus_if.mem2proc_ack = 1'b0; bus_if.mem2proc_data = 32'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_req", bus_if.proc2mem_req, 0);
    chk("rst_addr", bus_if.proc2mem_addr, 0);
    chk("rst_be", bus_if.proc2mem_be, 0);
    chk("rst_stall", stall, 0);
    chk("rst_valid", vout, 0);
    chk("rst_state", st, 0);

    // LW, single-cycle memory
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    chk("lw_addr", bus_if.proc2mem_addr, 32'h100);
    chk("lw_be", bus_if.proc2mem_be, 4'b1111);
    chk("lw_we", bus_if.proc2mem_we, 0);
    ack_with(32'hDEADBEEF);
    chk("lw_result", result, 32'hDEADBEEF);
    chk("lw_err", err, 0);
    tick();
    chk("lw_back_idle", st, 0);
    chk("lw_idle_valid", vout, 0);

    // Sub-word loads
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    ack_with(32'h80123456);
    chk("lb_sext", result, 32'hFFFFFF80);
    tick();
    issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
    ack_with(32'h80123456);
    chk("lbu_zext", result, 32'h00000080);
    tick();
    issue(1'b1, 1'b0, 3'b101, 32'h102, 32'h0);
    ack_with(32'hBEEF1234);
    chk("lhu_zext", result, 32'h0000BEEF);
    tick();
    issue(1'b1, 1'b0, 3'b001, 32'h100, 32'h0);
    ack_with(32'h12348001);
    chk("lh_sext", result, 32'hFFFF8001);
    tick();
    issue(1'b1, 1'b0, 3'b000, 32'h101, 32'h0);
    ack_with(32'h00007F00);
    chk("lb_lane1", result, 32'h0000007F);
    tick();

    // Stores
    issue(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB);
    chk("sb_addr", bus_if.proc2mem_addr, 32'h200);
    chk("sb_data", bus_if.proc2mem_data, 32'hABABABAB);
    chk("sb_be", bus_if.proc2mem_be, 4'b0010);
    chk("sb_we", bus_if.proc2mem_we, 1);
    ack_with(32'h11111111);
    chk("sb_result", result, 32'h0);
    chk("sb_err", err, 0);
    tick();
    issue(1'b0, 1'b1, 3'b001, 32'h302, 32'h1234ABCD);
    chk("sh_data", bus_if.proc2mem_data, 32'hABCDABCD);
    chk("sh_be", bus_if.proc2mem_be, 4'b1100);
    ack_with(32'h0);
    chk("sh_result", result, 32'h0);
    tick();

    // SW with a 3-cycle memory: request must stay stable
    issue(1'b0, 1'b1, 3'b010, 32'h104, 32'hCAFEF00D);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sw_hold_req", bus_if.proc2mem_req, 1);
      chk("sw_hold_stall", stall, 1);
      chk("sw_hold_addr", bus_if.proc2mem_addr, 32'h104);
    end
    chk("sw_data", bus_if.proc2mem_data, 32'hCAFEF00D);
    chk("sw_be", bus_if.proc2mem_be, 4'b1111);
    ack_with(32'h0);
    chk("sw_result", result, 32'h0);
    tick();

    // Malformed and non-memory instructions complete in IDLE
    valid = 1'b1; rd = 1'b1; wr = 1'b0; f3 = 3'b001; alu = 32'h101; #1;
    chk("lh_mis_stall", stall, 0);
    chk("lh_mis_valid", vout, 1);
    chk("lh_mis_err", err, 1);
    chk("lh_mis_result", result, 32'hbaadbeef);
    tick();
    chk("lh_mis_noreq", bus_if.proc2mem_req, 0);
    chk("lh_mis_state", st, 0);
    rd = 1'b0; wr = 1'b1; f3 = 3'b010; alu = 32'h102; #1;
    chk("sw_mis_err", err, 1);
    chk("sw_mis_result", result, 32'hbaadbeef);
    chk("sw_mis_stall", stall, 0);
    rd = 1'b1; wr = 1'b0; f3 = 3'b011; alu = 32'h100; #1;
    chk("f3_011_err", err, 1);
    f3 = 3'b110; #1;
    chk("f3_110_err", err, 1);
    rd = 1'b1; wr = 1'b1; f3 = 3'b010; #1;
    chk("rdwr_err", err, 1);
    chk("rdwr_stall", stall, 0);
    rd = 1'b0; wr = 1'b0; alu = 32'h55; #1;
    chk("add_result", result, 32'h55);
    chk("add_err", err, 0);
    chk("add_valid", vout, 1);
    valid = 1'b0; rd = 1'b1; #1;
    chk("inv_valid", vout, 0);
    chk("inv_stall", stall, 0);
    tick();
    chk("inv_noreq", bus_if.proc2mem_req, 0);
    rd = 1'b0;

    // Timeout: exactly T BUSY cycles, then DONE with error
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    for (int i = 0; i < T; i++) begin
      chk("to_req_held", bus_if.proc2mem_req, 1);
      tick();
    end
    valid = 1'b0; rd = 1'b0; #1;
    chk("to_req_drop", bus_if.proc2mem_req, 0);
    chk("to_valid", vout, 1);
    chk("to_err", err, 1);
    chk("to_result", result, 32'hbaadbeef);
    chk("to_stall", stall, 0);
    tick();
    tick(); tick();
    bus_if.mem2proc_ack = 1'b1; bus_if.mem2proc_data = 32'h12345678; #1;
    chk("late_ack_valid", vout, 0);
    chk("late_ack_stall", stall, 0);
    tick();
    bus_if.mem2proc_ack = 1'b0;
    chk("late_ack_state", st, 0);
    chk("late_ack_noreq", bus_if.proc2mem_req, 0);
    issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    ack_with(32'h0BADF00D);
    chk("post_to_lw", result, 32'h0BADF00D);
    chk("post_to_err", err, 0);
    tick();

    // Reset in the middle of an access
    issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    #2 rst = 1'b1; valid = 1'b0; rd = 1'b0;
    #1;
    chk("rst_busy_req", bus_if.proc2mem_req, 0);
    chk("rst_busy_state", st, 0);
    chk("rst_busy_stall", stall, 0);
    chk("rst_busy_valid", vout, 0);
    chk("rst_busy_result", result, 0);
    chk("rst_busy_addr", bus_if.proc2mem_addr, 0);
    tick();
    rst = 1'b0;
    bus_if.mem2proc_ack = 1'b1; bus_if.mem2proc_data = 32'hFFFFFFFF;
    tick();
    bus_if.mem2proc_ack = 1'b0; #1;
    chk("rst_ack_state", st, 0);
    chk("rst_ack_valid", vout, 0);
    chk("rst_ack_req", bus_if.proc2mem_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
